wb_port_arbiter: RTL and testbench

Owns the register-file write port and shares it between the in-order pipeline writeback (the ME/WB stage register outputs) and the long-latency unit (divider/multi-cycle ops) that completes out of band. Also keeps a 32-entry busy scoreboard of destinations still owed by the long-latency unit, and raises decode hazards and pipeline stall requests. It sits between the ME/WB register, the long-latency unit and the register file.

---
 rtl/wb_port_arbiter.sv | 93 +++++++++
 tb/tb_wb_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline writeback always wins,
// the long-latency unit fills idle slots and tracks the destinations it still owes.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        mc_issue,
    input  logic [4:0]  mc_issue_addr,
    input  logic        mc_valid,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        dec_hazard,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    localparam int CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    logic [31:0]     busy_q, busy_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            pipe_occ;
    logic            transfer;

    // A writeback to x0 is architecturally void, so it never takes the port.
    assign pipe_occ = pipe_we & (pipe_addr != 5'd0);
    assign mc_ready = ~rst & ~pipe_occ;
    assign transfer = mc_valid & mc_ready;

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (!rst) begin
            if (pipe_occ) begin
                rf_we   = 1'b1;
                rf_addr = pipe_addr;
                rf_data = pipe_data;
            end else if (mc_valid) begin
                rf_we   = (mc_addr != 5'd0);
                rf_addr = mc_addr;
                rf_data = mc_data;
            end
        end
    end

    // Issue is applied after the clear so a same-cycle set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (transfer) begin
            busy_d[mc_addr] = 1'b0;
        end
        if (mc_issue) begin
            busy_d[mc_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (transfer || !mc_valid) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CntMax) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 32'd0;
            wait_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign stall_req  = ~rst & (wait_cnt_q == CntMax);
    assign dec_hazard = ~rst & dec_valid &
                        (busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd]);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with literal
// expectations, then constrained-random traffic against a behavioural model.
module tb_wb_port_arbiter;

    localparam int Limit = 4;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mc_issue;
    logic [4:0]  mc_issue_addr;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_hazard;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: which registers are owed, and how long the
    // current long-latency result has been refused.
    bit owed[32];
    int waitCycles = 0;
    bit lastTransfer = 0;
    bit lastStall = 0;

    wb_port_arbiter #(.STARVE_LIMIT(Limit)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .mc_issue(mc_issue), .mc_issue_addr(mc_issue_addr),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data),
        .mc_ready(mc_ready),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_hazard(dec_hazard), .stall_req(stall_req),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        pipe_we = 0; pipe_addr = 0; pipe_data = 0;
        mc_issue = 0; mc_issue_addr = 0;
        mc_valid = 0; mc_addr = 0; mc_data = 0;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    // Model compare on every cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        bit occ, expReady, expWe, expTransfer, expStall, expHazard;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        if (rst) begin
            foreach (owed[i]) owed[i] = 0;
            waitCycles = 0;
            checkOutput("rst_mc_ready", {31'd0, mc_ready}, 32'd0);
            checkOutput("rst_rf_we", {31'd0, rf_we}, 32'd0);
            checkOutput("rst_stall_req", {31'd0, stall_req}, 32'd0);
            checkOutput("rst_dec_hazard", {31'd0, dec_hazard}, 32'd0);
            lastTransfer = 0;
            lastStall = 0;
        end else begin
            occ = pipe_we && (pipe_addr != 0);
            expReady = !occ;
            expTransfer = mc_valid && expReady;
            expStall = (waitCycles == Limit);
            expHazard = dec_valid && (owed[dec_rs1] || owed[dec_rs2] || owed[dec_rd]);
            if (occ) begin
                expWe = 1; expAddr = pipe_addr; expData = pipe_data;
            end else if (mc_valid) begin
                expWe = (mc_addr != 0); expAddr = mc_addr; expData = mc_data;
            end else begin
                expWe = 0; expAddr = 0; expData = 0;
            end
            checkOutput("mc_ready", {31'd0, mc_ready}, {31'd0, expReady});
            checkOutput("rf_we", {31'd0, rf_we}, {31'd0, expWe});
            checkOutput("rf_addr", {27'd0, rf_addr}, {27'd0, expAddr});
            checkOutput("rf_data", rf_data, expData);
            checkOutput("stall_req", {31'd0, stall_req}, {31'd0, expStall});
            checkOutput("dec_hazard", {31'd0, dec_hazard}, {31'd0, expHazard});
            if (expTransfer) owed[mc_addr] = 0;
            if (mc_issue && mc_issue_addr != 0) owed[mc_issue_addr] = 1;
            if (expTransfer || !mc_valid) waitCycles = 0;
            else if (waitCycles < Limit) waitCycles++;
            lastTransfer = expTransfer;
            lastStall = expStall;
        end
    end

    initial begin
        bit pending;
        bit stallPrev;
        clearInputs();
        rst = 1;
        pipe_we = 1; pipe_addr = 3; pipe_data = 32'h1111;
        repeat (2) applyStimulus();
        @(negedge clk); #1;
        checkOutput("lit_reset_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("lit_reset_mc_ready", {31'd0, mc_ready}, 32'd0);
        applyStimulus();
        rst = 0;
        clearInputs();

        // Idle pipeline: long-latency result goes straight through.
        mc_issue = 1; mc_issue_addr = 7;
        applyStimulus();
        mc_issue = 0;
        mc_valid = 1; mc_addr = 7; mc_data = 32'hDEADBEEF;
        dec_valid = 1; dec_rs1 = 7;
        @(negedge clk); #1;
        checkOutput("lit_idle_ready", {31'd0, mc_ready}, 32'd1);
        checkOutput("lit_idle_we", {31'd0, rf_we}, 32'd1);
        checkOutput("lit_idle_addr", {27'd0, rf_addr}, 32'd7);
        checkOutput("lit_idle_data", rf_data, 32'hDEADBEEF);
        checkOutput("lit_idle_hazard_before", {31'd0, dec_hazard}, 32'd1);
        applyStimulus();
        mc_valid = 0;
        @(negedge clk); #1;
        checkOutput("lit_idle_hazard_after", {31'd0, dec_hazard}, 32'd0);
        applyStimulus();
        clearInputs();

        // Contention: pipeline holds the port until the stall is honoured.
        mc_issue = 1; mc_issue_addr = 9;
        applyStimulus();
        mc_issue = 0;
        pipe_we = 1; pipe_addr = 3; pipe_data = 32'h33;
        mc_valid = 1; mc_addr = 9; mc_data = 32'h99;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checkOutput("lit_cont_addr", {27'd0, rf_addr}, 32'd3);
            checkOutput("lit_cont_ready", {31'd0, mc_ready}, 32'd0);
            checkOutput("lit_cont_stall", {31'd0, stall_req}, (k == 4) ? 32'd1 : 32'd0);
            applyStimulus();
        end
        pipe_we = 0;
        @(negedge clk); #1;
        checkOutput("lit_cont_xfer_ready", {31'd0, mc_ready}, 32'd1);
        checkOutput("lit_cont_xfer_addr", {27'd0, rf_addr}, 32'd9);
        checkOutput("lit_cont_xfer_data", rf_data, 32'h99);
        applyStimulus();
        mc_valid = 0;
        @(negedge clk); #1;
        checkOutput("lit_cont_stall_clear", {31'd0, stall_req}, 32'd0);
        applyStimulus();
        clearInputs();

        // x0 on both sides: port stays free and nothing is written.
        pipe_we = 1; pipe_addr = 0; pipe_data = 32'h55;
        mc_valid = 1; mc_addr = 0; mc_data = 32'h66;
        @(negedge clk); #1;
        checkOutput("lit_x0_ready", {31'd0, mc_ready}, 32'd1);
        checkOutput("lit_x0_we", {31'd0, rf_we}, 32'd0);
        applyStimulus();
        clearInputs();
        @(negedge clk); #1;
        checkOutput("lit_x0_stall", {31'd0, stall_req}, 32'd0);
        applyStimulus();

        // Scoreboard hazards and simultaneous set/clear on x12.
        mc_issue = 1; mc_issue_addr = 12;
        applyStimulus();
        mc_issue = 0;
        dec_valid = 1; dec_rs2 = 12;
        @(negedge clk); #1;
        checkOutput("lit_sb_rs2", {31'd0, dec_hazard}, 32'd1);
        dec_rs2 = 0; dec_rd = 12; #1;
        checkOutput("lit_sb_rd", {31'd0, dec_hazard}, 32'd1);
        dec_valid = 0; #1;
        checkOutput("lit_sb_novalid", {31'd0, dec_hazard}, 32'd0);
        applyStimulus();
        mc_issue = 1; mc_issue_addr = 12;
        mc_valid = 1; mc_addr = 12; mc_data = 32'hC;
        applyStimulus();
        clearInputs();
        dec_valid = 1; dec_rs1 = 12;
        @(negedge clk); #1;
        checkOutput("lit_sb_setwins", {31'd0, dec_hazard}, 32'd1);
        applyStimulus();
        mc_valid = 1; mc_addr = 12; mc_data = 32'hD;
        applyStimulus();
        mc_valid = 0;
        @(negedge clk); #1;
        checkOutput("lit_sb_cleared", {31'd0, dec_hazard}, 32'd0);
        applyStimulus();
        clearInputs();

        // Reset in the middle of a wait with a busy register.
        mc_issue = 1; mc_issue_addr = 5;
        applyStimulus();
        mc_issue = 0;
        pipe_we = 1; pipe_addr = 3; pipe_data = 32'h77;
        mc_valid = 1; mc_addr = 5; mc_data = 32'h88;
        dec_valid = 1; dec_rs1 = 5;
        repeat (3) applyStimulus();
        rst = 1;
        #1;
        checkOutput("lit_midrst_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("lit_midrst_we", {31'd0, rf_we}, 32'd0);
        checkOutput("lit_midrst_hazard", {31'd0, dec_hazard}, 32'd0);
        applyStimulus();
        rst = 0;
        pipe_we = 0; mc_valid = 0;
        @(negedge clk); #1;
        checkOutput("lit_postrst_hazard", {31'd0, dec_hazard}, 32'd0);
        applyStimulus();
        clearInputs();

        // Random traffic obeying the issue, hold and stall protocols.
        pending = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stallPrev = lastStall;
            if (lastTransfer) pending = 0;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1;
                pending = 0;
                clearInputs();
                applyStimulus();
                rst = 0;
                continue;
            end
            mc_issue = 0;
            if ($urandom_range(0, 3) == 0) begin
                logic [4:0] a;
                a = 5'($urandom_range(1, 31));
                if (!owed[a]) begin
                    mc_issue = 1; mc_issue_addr = a;
                end
            end
            if (!pending) begin
                mc_valid = 0;
                if ($urandom_range(0, 2) == 0) begin
                    mc_valid = 1;
                    mc_addr = 5'($urandom_range(0, 31));
                    for (int t = 0; t < 8; t++) begin
                        logic [4:0] b;
                        b = 5'($urandom_range(1, 31));
                        if (owed[b]) begin
                            mc_addr = b;
                            break;
                        end
                    end
                    mc_data = $urandom;
                    pending = 1;
                end
            end
            if (stallPrev) begin
                pipe_we = 0;
            end else begin
                pipe_we = ($urandom_range(0, 9) < 6);
            end
            pipe_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_data = $urandom;
            dec_valid = $urandom_range(0, 1);
            dec_rs1 = 5'($urandom_range(0, 31));
            dec_rs2 = 5'($urandom_range(0, 31));
            dec_rd  = 5'($urandom_range(0, 31));
            applyStimulus();
        end

        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
